// File: rtl/optical_flow_pkg.sv
// rtl/optical_flow_pkg.sv - shared tensor term enum and sum-width helper for the optical-flow datapath
package optical_flow_pkg;

  typedef enum logic [2:0] {
    TENSOR_XX,
    TENSOR_XY,
    TENSOR_YY,
    TENSOR_XT,
    TENSOR_YT
  } tensor_term_e;

  localparam int NUM_TENSOR_TERMS = 5;

  // Width that holds the sum of per-frame products without overflow.
  function automatic int tensor_sum_width(input int der_bits, input int num_frames);
    return 2 * der_bits + $clog2(num_frames);
  endfunction

endpackage

// File: rtl/tensor_product_sum.sv
// rtl/tensor_product_sum.sv - one tensor component: per-frame multiply, frame sum, shift and saturate (3 stages)
// Optional rounding before the shift when STRUCT_TENSOR_ROUND_EN is defined.
module tensor_product_sum
  import optical_flow_pkg::*;
#(
  parameter int DER_TRUNC_BITS = 8,
  parameter int NUM_FRAMES     = 3,
  parameter int PROD_SHIFT     = 2,
  parameter int OUT_BITS       = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [DER_TRUNC_BITS*NUM_FRAMES-1:0]  a_in,
  input  logic [DER_TRUNC_BITS*NUM_FRAMES-1:0]  b_in,
  output logic signed [OUT_BITS-1:0]            sum_out
);

  localparam int PROD_W = 2 * DER_TRUNC_BITS;
  localparam int SUM_W  = tensor_sum_width(DER_TRUNC_BITS, NUM_FRAMES);
  localparam int EXT_W  = SUM_W + 1;
  localparam int CMP_W  = (EXT_W > OUT_BITS) ? EXT_W : OUT_BITS + 1;

  localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN = {{(CMP_W-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

  logic signed [PROD_W-1:0]   prod_d [NUM_FRAMES];
  logic signed [PROD_W-1:0]   prod_q [NUM_FRAMES];
  logic signed [SUM_W-1:0]    sum_d;
  logic signed [SUM_W-1:0]    sum_q;
  logic signed [EXT_W-1:0]    biased;
  logic signed [EXT_W-1:0]    shifted;
  logic signed [CMP_W-1:0]    shifted_c;
  logic signed [OUT_BITS-1:0] sat_d;

  always_comb begin
    for (int f = 0; f < NUM_FRAMES; f++) begin
      prod_d[f] = PROD_W'($signed(a_in[f*DER_TRUNC_BITS +: DER_TRUNC_BITS]))
                * PROD_W'($signed(b_in[f*DER_TRUNC_BITS +: DER_TRUNC_BITS]));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int f = 0; f < NUM_FRAMES; f++) begin
      sum_d = sum_d + SUM_W'(prod_q[f]);
    end
  end

  // One guard bit above the sum keeps the rounding bias from wrapping.
`ifdef STRUCT_TENSOR_ROUND_EN
  if (PROD_SHIFT > 0) begin : g_round
    assign biased = EXT_W'(sum_q) + EXT_W'(1 << (PROD_SHIFT - 1));
  end else begin : g_floor
    assign biased = EXT_W'(sum_q);
  end
`else
  assign biased = EXT_W'(sum_q);
`endif

  assign shifted   = biased >>> PROD_SHIFT;
  assign shifted_c = CMP_W'(shifted);

  always_comb begin
    sat_d = shifted_c[OUT_BITS-1:0];
    if (shifted_c > SAT_MAX) begin
      sat_d = {1'b0, {(OUT_BITS-1){1'b1}}};
    end else if (shifted_c < SAT_MIN) begin
      sat_d = {1'b1, {(OUT_BITS-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < NUM_FRAMES; f++) begin
        prod_q[f] <= '0;
      end
      sum_q   <= '0;
      sum_out <= '0;
    end else if (en) begin
      for (int f = 0; f < NUM_FRAMES; f++) begin
        prod_q[f] <= prod_d[f];
      end
      sum_q   <= sum_d;
      sum_out <= sat_d;
    end
  end

endmodule

// File: rtl/structure_tensor_calc.sv
// rtl/structure_tensor_calc.sv - five gradient-product sums with raster sof/eol markers, 3-cycle pipeline
// Optional rounding in the shift stage is selected by STRUCT_TENSOR_ROUND_EN.
module structure_tensor_calc
  import optical_flow_pkg::*;
#(
  parameter int DER_TRUNC_BITS        = 8,
  parameter int NUM_DERIVATIVE_FRAMES = 3,
  parameter int FRAME_WIDTH           = 1024,
  parameter int FRAME_HEIGHT          = 768,
  parameter int PROD_SHIFT            = 2,
  parameter int OUT_BITS              = 16
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              en,
  input  logic                                              in_valid,
  input  logic [DER_TRUNC_BITS*NUM_DERIVATIVE_FRAMES-1:0]   temp_derivs_in,
  input  logic [DER_TRUNC_BITS*NUM_DERIVATIVE_FRAMES-1:0]   x_derivs_in,
  input  logic [DER_TRUNC_BITS*NUM_DERIVATIVE_FRAMES-1:0]   y_derivs_in,
  output logic signed [OUT_BITS-1:0]                        sxx_out,
  output logic signed [OUT_BITS-1:0]                        sxy_out,
  output logic signed [OUT_BITS-1:0]                        syy_out,
  output logic signed [OUT_BITS-1:0]                        sxt_out,
  output logic signed [OUT_BITS-1:0]                        syt_out,
  output logic                                              out_valid,
  output logic                                              out_sof,
  output logic                                              out_eol
);

  localparam int VEC_W = DER_TRUNC_BITS * NUM_DERIVATIVE_FRAMES;
  localparam int COL_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             col_last;
  logic             row_last;
  logic [2:0]       vld_pipe;
  logic [2:0]       sof_pipe;
  logic [2:0]       eol_pipe;

  logic signed [OUT_BITS-1:0] term_sum [NUM_TENSOR_TERMS];

  assign accept   = en && in_valid;
  assign col_last = (col == COL_W'(FRAME_WIDTH - 1));
  assign row_last = (row == ROW_W'(FRAME_HEIGHT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Markers are tagged at acceptance and ride alongside the data pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
      eol_pipe <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[1:0], in_valid};
      sof_pipe <= {sof_pipe[1:0], in_valid && (col == '0) && (row == '0)};
      eol_pipe <= {eol_pipe[1:0], in_valid && col_last};
    end
  end

  assign out_valid = vld_pipe[2];
  assign out_sof   = sof_pipe[2];
  assign out_eol   = eol_pipe[2];

  for (genvar t = 0; t < NUM_TENSOR_TERMS; t++) begin : g_term
    localparam tensor_term_e TERM = tensor_term_e'(t);
    logic [VEC_W-1:0] a_sel;
    logic [VEC_W-1:0] b_sel;

    always_comb begin
      a_sel = x_derivs_in;
      b_sel = y_derivs_in;
      case (TERM)
        TENSOR_XX: b_sel = x_derivs_in;
        TENSOR_YY: a_sel = y_derivs_in;
        TENSOR_XT: b_sel = temp_derivs_in;
        TENSOR_YT: begin
          a_sel = y_derivs_in;
          b_sel = temp_derivs_in;
        end
        default: ;
      endcase
    end

    tensor_product_sum #(
      .DER_TRUNC_BITS(DER_TRUNC_BITS),
      .NUM_FRAMES    (NUM_DERIVATIVE_FRAMES),
      .PROD_SHIFT    (PROD_SHIFT),
      .OUT_BITS      (OUT_BITS)
    ) u_sum (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .a_in   (a_sel),
      .b_in   (b_sel),
      .sum_out(term_sum[t])
    );
  end

  assign sxx_out = term_sum[TENSOR_XX];
  assign sxy_out = term_sum[TENSOR_XY];
  assign syy_out = term_sum[TENSOR_YY];
  assign sxt_out = term_sum[TENSOR_XT];
  assign syt_out = term_sum[TENSOR_YT];

endmodule

// File: tb/tb_structure_tensor_calc.sv
// tb/tb_structure_tensor_calc.sv - table-driven bench for structure_tensor_calc (STRUCT_TENSOR_ROUND_EN aware)
module tb_structure_tensor_calc;

`ifdef STRUCT_TENSOR_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  localparam int VW = 24;
  localparam int NV = 6;

  logic clk = 1'b0;
  logic rst, en, in_valid;
  logic [VW-1:0] t_in, x_in, y_in;
  logic signed [15:0] sxx, sxy, syy, sxt, syt;
  logic ov, osof, oeol;
  logic signed [15:0] s_sxx, s_sxy, s_syy, s_sxt, s_syt;
  logic s_ov, s_sof, s_eol;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  structure_tensor_calc #(
    .DER_TRUNC_BITS(8), .NUM_DERIVATIVE_FRAMES(3), .FRAME_WIDTH(4), .FRAME_HEIGHT(2),
    .PROD_SHIFT(2), .OUT_BITS(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .temp_derivs_in(t_in), .x_derivs_in(x_in), .y_derivs_in(y_in),
    .sxx_out(sxx), .sxy_out(sxy), .syy_out(syy), .sxt_out(sxt), .syt_out(syt),
    .out_valid(ov), .out_sof(osof), .out_eol(oeol)
  );

  structure_tensor_calc #(
    .DER_TRUNC_BITS(8), .NUM_DERIVATIVE_FRAMES(3), .FRAME_WIDTH(4), .FRAME_HEIGHT(2),
    .PROD_SHIFT(0), .OUT_BITS(16)
  ) dut_sat (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .temp_derivs_in(t_in), .x_derivs_in(x_in), .y_derivs_in(y_in),
    .sxx_out(s_sxx), .sxy_out(s_sxy), .syy_out(s_syy), .sxt_out(s_sxt), .syt_out(s_syt),
    .out_valid(s_ov), .out_sof(s_sof), .out_eol(s_eol)
  );

  typedef struct packed {
    logic [VW-1:0] x;
    logic [VW-1:0] y;
    logic [VW-1:0] t;
    int e_xx, e_xy, e_yy, e_xt, e_yt;
    int s_xx, s_xy, s_syy, s_xt, s_yt;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [VW-1:0] pk(input int a0, input int a1, input int a2);
    logic [7:0] b0, b1, b2;
    b0 = a0[7:0];
    b1 = a1[7:0];
    b2 = a2[7:0];
    return {b2, b1, b0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    x_in = v.x;
    y_in = v.y;
    t_in = v.t;
  endtask

  task automatic check_out(input vec_t v, input string tag);
    chk({tag, " valid"}, int'(ov), 1);
    chk({tag, " sxx"}, int'(sxx), v.e_xx);
    chk({tag, " sxy"}, int'(sxy), v.e_xy);
    chk({tag, " syy"}, int'(syy), v.e_yy);
    chk({tag, " sxt"}, int'(sxt), v.e_xt);
    chk({tag, " syt"}, int'(syt), v.e_yt);
    chk({tag, " sat valid"}, int'(s_ov), 1);
    chk({tag, " sat sxx"}, int'(s_sxx), v.s_xx);
    chk({tag, " sat sxy"}, int'(s_sxy), v.s_xy);
    chk({tag, " sat syy"}, int'(s_syy), v.s_syy);
    chk({tag, " sat sxt"}, int'(s_sxt), v.s_xt);
    chk({tag, " sat syt"}, int'(s_syt), v.s_yt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " valid"}, int'(ov), 0);
    chk({tag, " sof"}, int'(osof), 0);
    chk({tag, " eol"}, int'(oeol), 0);
    chk({tag, " sxx"}, int'(sxx), 0);
    chk({tag, " sxy"}, int'(sxy), 0);
    chk({tag, " syy"}, int'(syy), 0);
    chk({tag, " sxt"}, int'(sxt), 0);
    chk({tag, " syt"}, int'(syt), 0);
    chk({tag, " sat valid"}, int'(s_ov), 0);
    chk({tag, " sat sof"}, int'(s_sof), 0);
    chk({tag, " sat eol"}, int'(s_eol), 0);
    chk({tag, " sat sxx"}, int'(s_sxx), 0);
  endtask

  initial begin
    int pat [13];
    int tagk [16];
    int k;

    vecs[0] = '{pk(10,10,10), pk(-5,-5,-5), pk(3,3,3),
                75, ROUND ? -37 : -38, ROUND ? 19 : 18, ROUND ? 23 : 22, ROUND ? -11 : -12,
                300, -150, 75, 90, -45};
    vecs[1] = '{pk(-128,-128,-128), pk(127,127,127), pk(0,0,0),
                12288, -12192, ROUND ? 12097 : 12096, 0, 0,
                32767, -32768, 32767, 0, 0};
    vecs[2] = '{pk(1,-4,7), pk(2,5,-8), pk(3,-6,9),
                ROUND ? 17 : 16, ROUND ? -18 : -19, 23, ROUND ? 23 : 22, -24,
                66, -74, 93, 90, -96};
    vecs[3] = '{pk(0,0,0), pk(0,0,0), pk(0,0,0),
                0, 0, 0, 0, 0,
                0, 0, 0, 0, 0};
    vecs[4] = '{pk(-1,-1,-1), pk(-1,-1,-1), pk(1,1,1),
                ROUND ? 1 : 0, ROUND ? 1 : 0, ROUND ? 1 : 0, -1, -1,
                3, 3, 3, -3, -3};
    vecs[5] = '{pk(127,127,127), pk(127,127,127), pk(127,127,127),
                ROUND ? 12097 : 12096, ROUND ? 12097 : 12096, ROUND ? 12097 : 12096,
                ROUND ? 12097 : 12096, ROUND ? 12097 : 12096,
                32767, 32767, 32767, 32767, 32767};

    pat = '{1,1,0,1,1,1,0,0,1,1,0,1,1};

    rst = 1'b1;
    en = 1'b0;
    in_valid = 1'b0;
    x_in = '0;
    y_in = '0;
    t_in = '0;
    #1;
    check_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    en = 1'b1;

    // Back-to-back vectors; each emerges after three enabled edges.
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) begin
        drive(vecs[i]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 2) check_out(vecs[i-2], $sformatf("vec%0d", i - 2));
    end

    // en stall with a valid result on the outputs and another in flight.
    drive(vecs[2]); in_valid = 1'b1; tick();
    drive(vecs[0]); in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    check_out(vecs[2], "stall pre");
    en = 1'b0;
    drive(vecs[5]);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("stall%0d valid", c), int'(ov), 1);
      chk($sformatf("stall%0d sxx hold", c), int'(sxx), vecs[2].e_xx);
      chk($sformatf("stall%0d syt hold", c), int'(syt), vecs[2].e_yt);
      chk($sformatf("stall%0d sat sxy hold", c), int'(s_sxy), vecs[2].s_xy);
    end
    en = 1'b1;
    in_valid = 1'b0;
    tick();
    check_out(vecs[0], "stall post");
    tick();
    chk("stall bubble valid", int'(ov), 0);
    chk("stall bubble sat valid", int'(s_ov), 0);

    // Async reset between edges while valid data is on the outputs.
    drive(vecs[0]);
    in_valid = 1'b1;
    tick(); tick(); tick();
    chk("prereset valid", int'(ov), 1);
    chk("prereset sxx", int'(sxx), vecs[0].e_xx);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async reset");
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Raster markers with bubbles: first pixel after reset is (0,0).
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 13 && pat[i] == 1) begin
        x_in = pk(k, k, k);
        y_in = '0;
        t_in = '0;
        in_valid = 1'b1;
        tagk[i] = k;
        k++;
      end else begin
        in_valid = 1'b0;
        tagk[i] = -1;
      end
      tick();
      if (i >= 2) begin
        if (tagk[i-2] >= 0) begin
          chk($sformatf("raster px%0d valid", tagk[i-2]), int'(ov), 1);
          chk($sformatf("raster px%0d sof", tagk[i-2]), int'(osof),
              (tagk[i-2] == 0 || tagk[i-2] == 8) ? 1 : 0);
          chk($sformatf("raster px%0d eol", tagk[i-2]), int'(oeol),
              (tagk[i-2] == 3 || tagk[i-2] == 7) ? 1 : 0);
          chk($sformatf("raster px%0d sxx", tagk[i-2]), int'(sxx),
              (3 * tagk[i-2] * tagk[i-2] + (ROUND ? 2 : 0)) >>> 2);
        end else begin
          chk($sformatf("raster bubble%0d valid", i - 2), int'(ov), 0);
          chk($sformatf("raster bubble%0d sof", i - 2), int'(osof), 0);
          chk($sformatf("raster bubble%0d eol", i - 2), int'(oeol), 0);
        end
      end
    end
    chk("raster accepted count", k, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/structure_tensor_calc.md
Name: structure_tensor_calc

Overview:
- Downstream neighbour of the derivative stage. Consumes the saturated, packed temporal, x and y derivatives for NUM_DERIVATIVE_FRAMES frames at one pixel location.
- Produces the five gradient-product sums used by the flow solver: Sxx, Sxy, Syy, Sxt, Syt.
- Pipelined at 3 cycles, gated by en.
- Tracks raster position so the solver receives start-of-frame and end-of-line markers aligned with the data.

Parameters:
- DER_TRUNC_BITS, 8, signed width of each input derivative.
- NUM_DERIVATIVE_FRAMES, 3, derivative frames per pixel, summed together.
- FRAME_WIDTH, 1024, pixels per line.
- FRAME_HEIGHT, 768, lines per frame.
- PROD_SHIFT, 2, arithmetic right shift applied to each raw sum before saturation.
- OUT_BITS, 16, signed width of each output sum.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  pipeline advance enable; when low, all state holds.
- in_valid  in  1  input derivatives valid this cycle.
- temp_derivs_in  in  DER_TRUNC_BITS*NUM_DERIVATIVE_FRAMES  packed signed It, frame 0 at LSBs.
- x_derivs_in  in  DER_TRUNC_BITS*NUM_DERIVATIVE_FRAMES  packed signed Ix.
- y_derivs_in  in  DER_TRUNC_BITS*NUM_DERIVATIVE_FRAMES  packed signed Iy.
- sxx_out, sxy_out, syy_out, sxt_out, syt_out  out  OUT_BITS each  signed sums.
- out_valid  out  1  output sums valid.
- out_sof  out  1  output is pixel (row 0, col 0).
- out_eol  out  1  output is col FRAME_WIDTH-1.

Behaviour:
- Reset (async, rst=1): all pipeline registers, sums, out_valid/out_sof/out_eol and col/row counters go to 0 immediately. Reset mid-frame discards in-flight data; the first accepted input after release is treated as (0,0).
- An input is accepted when en && in_valid. When en=0 nothing changes, including counters and outputs.
- Stage 1: per frame f, register the signed products Ix*Ix, Ix*Iy, Iy*Iy, Ix*It, Iy*It. Each product is 2*DER_TRUNC_BITS wide.
- Stage 2: sum each product over frames. Sum width is 2*DER_TRUNC_BITS + clog2(NUM_DERIVATIVE_FRAMES); no overflow is possible at this width.
- Stage 3: arithmetic shift right by PROD_SHIFT, then saturate to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1] and register to the outputs.
- Latency: exactly 3 enabled cycles from acceptance to out_valid=1. Outputs hold their value while en=0.
- Valid and markers travel in a 3-deep shift register beside the data.
  - If in_valid=0 on an enabled cycle, a bubble propagates: out_valid=0 three enabled cycles later.
  - Data registers may update on bubbles; the bench checks data only when out_valid=1.
- Position counters col and row advance only on accepted inputs.
  - col wraps FRAME_WIDTH-1 -> 0 and increments row at the same time.
  - row wraps FRAME_HEIGHT-1 -> 0 when col also wraps.
  - sof tag = (col==0 && row==0); eol tag = (col==FRAME_WIDTH-1); both are captured at acceptance.
- Boundary at the last pixel of a frame (col=FRAME_WIDTH-1, row=FRAME_HEIGHT-1): that pixel carries eol. The next accepted pixel carries sof.
- Sxx and Syy are non-negative before saturation. Saturation still applies when the shifted sum exceeds the positive limit.

Optional Feature:
- Macro: STRUCT_TENSOR_ROUND_EN.
- Defined: stage 3 adds 2^(PROD_SHIFT-1) before the shift (round half toward +inf). Rounding applies only when PROD_SHIFT>0.
- Undefined: plain arithmetic shift (floor). Latency is unchanged in both cases.

Decomposition:
- Package optical_flow_pkg holds:
  - Tensor component enum: TENSOR_XX, TENSOR_XY, TENSOR_YY, TENSOR_XT, TENSOR_YT.
  - localparam NUM_TENSOR_TERMS = 5.
  - A function computing the sum width from DER_TRUNC_BITS and NUM_DERIVATIVE_FRAMES.
- Sub-module tensor_product_sum covers one component: multiply per frame, sum, shift, saturate, with 3 register stages. It is instantiated 5 times.
- Counters and the marker pipeline live in the top module.

Test Plan:
- Smoke: all frames Ix=10, Iy=-5, It=3, PROD_SHIFT=2, macro off, one accepted input -> 3 cycles later out_valid=1, Sxx=75, Sxy=-38, Syy=18, Sxt=22, Syt=-12.
- Rounding: same stimulus with STRUCT_TENSOR_ROUND_EN defined -> Sxx=75, Sxy=-37, Syy=19, Sxt=23, Syt=-11.
- Saturation: PROD_SHIFT=0, OUT_BITS=16, all Ix=-128, Iy=127, It=0 -> Sxx=32767 (raw 49152), Syy=32767 (raw 48387), Sxy=-32768 (raw -48768), Sxt=Syt=0.
- en stall: accept input, drop en low for 5 cycles, then raise it -> out_valid rises only on the 3rd enabled cycle and outputs hold throughout the stall.
- Raster markers: FRAME_WIDTH=4, FRAME_HEIGHT=2, stream 9 accepted pixels with bubbles inserted -> out_sof on outputs 0 and 8, out_eol on outputs 3 and 7, no output during bubbles.
- Async reset: assert rst between clock edges mid-stream -> outputs go to 0 immediately. After release, the next accepted pixel is emitted with out_sof=1.
